traffic_chk: RTL and testbench
==============================

TRAFFIC_CHK -- requirements
Module: traffic_chk

Interface
REQ-001 SHALL have parameter MAX_ETH_FRAME, default 4096, maximum frame length in bytes.
REQ-002 SHALL have parameter TX_LEN, default 512, stream data width in bits; TX_BEN = TX_LEN/8 bytes per beat.
REQ-003 SHALL have port axi_aclk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port axi_aresetn, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port control_reg, input, 32 bits; bit1 is start, bit2 is abort.
REQ-006 SHALL have ports txr_size, input, 16 bits (packet bytes, 64 minimum), and num_pkt, input, 16 bits (expected packet count).
REQ-007 SHALL have ports h2c_valid (input, 1), h2c_data (input, TX_LEN), h2c_last (input, 1) and h2c_ready (output, 1), forming an AXI-stream sink.
REQ-008 SHALL have outputs pkt_count (16), err_count (16), first_err_pkt (16), byte_count (32), cycle_count (32), done (1) and err_flag (1).

Function
REQ-009 SHALL implement three states: IDLE, RUN and DONE.
REQ-010 SHALL register control_reg[1] once; a 0->1 edge of the registered bit in IDLE or DONE SHALL enter RUN.
- Same cycle: latch txr_size and num_pkt.
- Same cycle: clear all counters, err_flag and done.
REQ-011 SHALL drive h2c_ready high only in RUN; a beat is accepted when h2c_valid and h2c_ready are both high.
REQ-012 SHALL split each packet into frames of min(remaining bytes, MAX_ETH_FRAME) bytes.
- Frames are back-to-back beats; each frame starts on a new beat.
- A frame of F bytes occupies ceil(F/TX_BEN) beats.
REQ-013 SHALL check bytes 0..13 of each frame's first beat as, in order: 21 21 11 22 33 44 55 66 11 22 33 44 55 66 (hex).
REQ-014 SHALL check frame bytes 14..F-5 as 0x41, and frame bytes F-4..F-1 as 21 21 21 0A (hex).
REQ-015 SHALL ignore beat bytes at frame offsets of F or more.
REQ-016 SHALL require h2c_last high exactly on the final beat of the packet's final frame; h2c_last on any other beat, or low on that beat, is a length error.
REQ-017 SHALL end the packet on an early h2c_last; the next accepted beat begins a new packet.
REQ-018 SHALL mark a packet errored on any header, payload, trailer or length mismatch.
- err_count increments at most once per packet and saturates at 0xFFFF.
- first_err_pkt latches the 0-based index of the first errored packet.
- err_flag is sticky until the next start.
REQ-019 SHALL update pkt_count (+1) and err_count one cycle after the packet's final accepted beat.
REQ-020 SHALL add the bytes of each accepted beat to byte_count, counting only bytes below frame size F.
REQ-021 SHALL have cycle_count run from the first accepted beat after start until done is set, inclusive.
REQ-022 SHALL, when pkt_count reaches num_pkt, enter DONE, set done=1 and drop h2c_ready in the same cycle.
- num_pkt=0 SHALL enter DONE the cycle after start.
REQ-023 SHALL, when the registered control_reg[2] is high, return to IDLE next cycle with counters held and done=0; abort has priority over start.
REQ-024 SHALL compute offsets in 16-bit arithmetic; txr_size up to 65535 SHALL not wrap.

Reset
REQ-025 SHALL, on axi_aresetn low, immediately force: state IDLE, h2c_ready=0, done=0, err_flag=0, all counters 0, latched sizes 0.
REQ-026 SHALL, on reset mid-packet, discard the partial packet; the next start restarts checking from a frame header.

Verification
REQ-027 SHALL cover: txr_size=64, num_pkt=1, one correct beat with last -> pkt_count=1, err_count=0, byte_count=64, done=1 one cycle after the beat.
REQ-028 SHALL cover: txr_size=8192, two 4096-byte frames, 128 beats, last only on beat 128 -> pkt_count=1, err_count=0.
REQ-029 SHALL cover: txr_size=100, num_pkt=1, 2 beats, trailer at bytes 96..99, bytes 100..127 = 0xFF -> no error, byte_count=100.
REQ-030 SHALL cover: num_pkt=3, byte 20 of packet 1 corrupted -> err_count=1, first_err_pkt=1, err_flag=1, pkt_count=3.
REQ-031 SHALL cover: txr_size=128, last on beat 1 -> length error, err_count=1; the next correct packet is counted clean.
REQ-032 SHALL cover: axi_aresetn pulsed low mid-packet -> all outputs 0 asynchronously, and a fresh start passes a clean 64-byte packet.

Source files
------------

// File: rtl/traffic_chk.sv
// Receive-side checker for a test traffic stream. Each packet arrives as one or
// more frames of at most MAX_ETH_FRAME bytes. The checker compares header,
// payload and trailer bytes, checks h2c_last placement, and keeps packet,
// error, byte and cycle counters for software to read.
`timescale 1ns/1ps
module traffic_chk #(
    parameter int MAX_ETH_FRAME = 4096,
    parameter int TX_LEN        = 512
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [31:0]       control_reg,
    input  logic [15:0]       txr_size,
    input  logic [15:0]       num_pkt,
    input  logic              h2c_valid,
    input  logic [TX_LEN-1:0] h2c_data,
    input  logic              h2c_last,
    output logic              h2c_ready,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_pkt,
    output logic [31:0]       byte_count,
    output logic [31:0]       cycle_count,
    output logic              done,
    output logic              err_flag
);
    localparam int          TX_BEN     = TX_LEN / 8;
    localparam logic [16:0] MAX_FRAME  = 17'(MAX_ETH_FRAME);
    localparam logic [16:0] BEAT_BYTES = 17'(TX_BEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        startReg_q, startPrev_q, abort_q;
    logic [15:0] txrSize_q, txrSize_d, numPkt_q, numPkt_d;
    logic [15:0] rem_q, rem_d, off_q, off_d;
    logic        pktErr_q, pktErr_d, cycleRun_q, cycleRun_d;
    logic [15:0] pktCount_q, pktCount_d, errCount_q, errCount_d;
    logic [15:0] firstErr_q, firstErr_d;
    logic [31:0] byteCount_q, byteCount_d, cycleCount_q, cycleCount_d;
    logic        errFlag_q, errFlag_d;

    logic        startEdge, accept, frameEndBeat, lastExpected;
    logic        dataErr, beatErr, pktEnd;
    logic [15:0] frameSize, frameLeft, beatBytes;
    logic [16:0] byteOff;
    logic [7:0]  expByte;
    logic        unusedCtrl;

    assign unusedCtrl = ^{control_reg[31:3], control_reg[0]};

    function automatic logic [7:0] hdrByte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1:  return 8'h21;
            4'd2, 4'd8:  return 8'h11;
            4'd3, 4'd9:  return 8'h22;
            4'd4, 4'd10: return 8'h33;
            4'd5, 4'd11: return 8'h44;
            4'd6, 4'd12: return 8'h55;
            4'd7, 4'd13: return 8'h66;
            default:     return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] trlByte(input logic [1:0] idx);
        return (idx == 2'd3) ? 8'h0A : 8'h21;
    endfunction

    // Locate the current beat inside its frame and compare every in-frame byte
    always_comb begin
        startEdge    = startReg_q & ~startPrev_q;
        accept       = (state_q == RUN) & h2c_valid;
        frameSize    = ({1'b0, rem_q} < MAX_FRAME) ? rem_q : MAX_FRAME[15:0];
        frameLeft    = frameSize - off_q;
        frameEndBeat = ({1'b0, frameLeft} <= BEAT_BYTES);
        lastExpected = ({1'b0, rem_q} <= MAX_FRAME) & frameEndBeat;
        beatBytes    = frameEndBeat ? frameLeft : BEAT_BYTES[15:0];
        dataErr      = 1'b0;
        byteOff      = '0;
        expByte      = 8'h41;
        for (int i = 0; i < TX_BEN; i++) begin
            byteOff = {1'b0, off_q} + 17'(i);
            expByte = 8'h41;
            if (byteOff < 17'd14) begin
                expByte = hdrByte(byteOff[3:0]);
            end else if (byteOff + 17'd4 >= {1'b0, frameSize}) begin
                expByte = trlByte(2'(byteOff + 17'd4 - {1'b0, frameSize}));
            end
            if ((byteOff < {1'b0, frameSize}) && (h2c_data[8*i +: 8] != expByte)) begin
                dataErr = 1'b1;
            end
        end
        beatErr = dataErr | (h2c_last != lastExpected);
        pktEnd  = accept & (h2c_last | lastExpected);
    end

    // Next-state and counter updates; abort beats start, start only from IDLE/DONE
    always_comb begin
        state_d      = state_q;
        txrSize_d    = txrSize_q;
        numPkt_d     = numPkt_q;
        rem_d        = rem_q;
        off_d        = off_q;
        pktErr_d     = pktErr_q;
        cycleRun_d   = cycleRun_q;
        pktCount_d   = pktCount_q;
        errCount_d   = errCount_q;
        firstErr_d   = firstErr_q;
        byteCount_d  = byteCount_q;
        cycleCount_d = cycleCount_q;
        errFlag_d    = errFlag_q;
        if (abort_q) begin
            state_d = IDLE;
        end else if (startEdge && (state_q != RUN)) begin
            state_d      = RUN;
            txrSize_d    = txr_size;
            numPkt_d     = num_pkt;
            rem_d        = txr_size;
            off_d        = '0;
            pktErr_d     = 1'b0;
            cycleRun_d   = 1'b0;
            pktCount_d   = '0;
            errCount_d   = '0;
            firstErr_d   = '0;
            byteCount_d  = '0;
            cycleCount_d = '0;
            errFlag_d    = 1'b0;
        end else if (state_q == RUN) begin
            if (accept) begin
                byteCount_d = byteCount_q + {16'd0, beatBytes};
                cycleRun_d  = 1'b1;
                if (pktEnd) begin
                    pktCount_d = pktCount_q + 16'd1;
                    rem_d      = txrSize_q;
                    off_d      = '0;
                    pktErr_d   = 1'b0;
                    if (pktErr_q | beatErr) begin
                        if (errCount_q != 16'hFFFF) begin
                            errCount_d = errCount_q + 16'd1;
                        end
                        if (!errFlag_q) begin
                            firstErr_d = pktCount_q;
                        end
                        errFlag_d = 1'b1;
                    end
                end else if (frameEndBeat) begin
                    rem_d    = rem_q - frameSize;
                    off_d    = '0;
                    pktErr_d = pktErr_q | beatErr;
                end else begin
                    off_d    = off_q + BEAT_BYTES[15:0];
                    pktErr_d = pktErr_q | beatErr;
                end
            end
            if (cycleRun_q | accept) begin
                cycleCount_d = cycleCount_q + 32'd1;
            end
            if (pktCount_d == numPkt_q) begin
                state_d = DONE;
            end
        end
    end

    // State, counters and sampled control bits
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            startReg_q   <= 1'b0;
            startPrev_q  <= 1'b0;
            abort_q      <= 1'b0;
            txrSize_q    <= '0;
            numPkt_q     <= '0;
            rem_q        <= '0;
            off_q        <= '0;
            pktErr_q     <= 1'b0;
            cycleRun_q   <= 1'b0;
            pktCount_q   <= '0;
            errCount_q   <= '0;
            firstErr_q   <= '0;
            byteCount_q  <= '0;
            cycleCount_q <= '0;
            errFlag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            startReg_q   <= control_reg[1];
            startPrev_q  <= startReg_q;
            abort_q      <= control_reg[2];
            txrSize_q    <= txrSize_d;
            numPkt_q     <= numPkt_d;
            rem_q        <= rem_d;
            off_q        <= off_d;
            pktErr_q     <= pktErr_d;
            cycleRun_q   <= cycleRun_d;
            pktCount_q   <= pktCount_d;
            errCount_q   <= errCount_d;
            firstErr_q   <= firstErr_d;
            byteCount_q  <= byteCount_d;
            cycleCount_q <= cycleCount_d;
            errFlag_q    <= errFlag_d;
        end
    end

    assign h2c_ready     = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign err_flag      = errFlag_q;
    assign pkt_count     = pktCount_q;
    assign err_count     = errCount_q;
    assign first_err_pkt = firstErr_q;
    assign byte_count    = byteCount_q;
    assign cycle_count   = cycleCount_q;

endmodule

// File: tb/tb_traffic_chk.sv
// Directed-vector bench for traffic_chk: builds correct, corrupted and
// truncated packets and compares the counters against hand-computed values.
`timescale 1ns/1ps
module tb_traffic_chk;
    localparam int TX_LEN = 512;
    localparam int BEN    = TX_LEN / 8;

    logic              axi_aclk = 1'b0;
    logic              axi_aresetn;
    logic [31:0]       control_reg;
    logic [15:0]       txr_size, num_pkt;
    logic              h2c_valid, h2c_last, h2c_ready;
    logic [TX_LEN-1:0] h2c_data;
    logic [15:0]       pkt_count, err_count, first_err_pkt;
    logic [31:0]       byte_count, cycle_count;
    logic              done, err_flag;

    int checkCount = 0;
    int errorCount = 0;

    traffic_chk #(.MAX_ETH_FRAME(4096), .TX_LEN(TX_LEN)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .control_reg(control_reg),
        .txr_size(txr_size), .num_pkt(num_pkt), .h2c_valid(h2c_valid),
        .h2c_data(h2c_data), .h2c_last(h2c_last), .h2c_ready(h2c_ready),
        .pkt_count(pkt_count), .err_count(err_count), .first_err_pkt(first_err_pkt),
        .byte_count(byte_count), .cycle_count(cycle_count), .done(done), .err_flag(err_flag)
    );

    // Free-running clock
    always #5 axi_aclk = ~axi_aclk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] refHeader(input int k);
        logic [111:0] hdrVec;
        hdrVec = 112'h2121_1122_3344_5566_1122_3344_5566;
        return hdrVec[8*(13-k) +: 8];
    endfunction

    // Reference frame contents for one beat starting at frame offset fOff
    function automatic logic [TX_LEN-1:0] makeBeat(input int fOff, input int fSize);
        logic [TX_LEN-1:0] d;
        int o;
        d = '0;
        for (int j = 0; j < BEN; j++) begin
            o = fOff + j;
            if (o >= fSize)          d[8*j +: 8] = 8'hFF;
            else if (o < 14)         d[8*j +: 8] = refHeader(o);
            else if (o == fSize - 1) d[8*j +: 8] = 8'h0A;
            else if (o >= fSize - 4) d[8*j +: 8] = 8'h21;
            else                     d[8*j +: 8] = 8'h41;
        end
        return d;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ready"}, h2c_ready, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " errFlag"}, err_flag, 0);
        checkOutput({tag, " pktCount"}, pkt_count, 0);
        checkOutput({tag, " errCount"}, err_count, 0);
        checkOutput({tag, " firstErr"}, first_err_pkt, 0);
        checkOutput({tag, " byteCount"}, byte_count, 0);
        checkOutput({tag, " cycleCount"}, cycle_count, 0);
    endtask

    task automatic startRun(input int size, input int npkt);
        control_reg = 32'h0;
        repeat (2) @(posedge axi_aclk);
        #1;
        txr_size    = 16'(size);
        num_pkt     = 16'(npkt);
        control_reg = 32'h2;
        repeat (2) @(posedge axi_aclk);
        #1;
        control_reg = 32'h0;
    endtask

    // Send one packet; corruptOff flips a first-frame byte, earlyLastBeat forces h2c_last
    task automatic applyStimulus(input int size, input int corruptOff, input int earlyLastBeat);
        int rem, fSize, beat;
        logic [TX_LEN-1:0] d;
        logic lastFlag;
        bit finished;
        rem = size;
        beat = 0;
        finished = 0;
        while (!finished && rem > 0) begin
            fSize = (rem < 4096) ? rem : 4096;
            for (int fOff = 0; fOff < fSize && !finished; fOff += BEN) begin
                d = makeBeat(fOff, fSize);
                if (rem == size && corruptOff >= fOff && corruptOff < fOff + BEN) begin
                    d[8*(corruptOff - fOff) +: 8] = d[8*(corruptOff - fOff) +: 8] ^ 8'h01;
                end
                lastFlag = (rem == fSize) && (fOff + BEN >= fSize);
                if (beat == earlyLastBeat) lastFlag = 1'b1;
                h2c_valid = 1'b1;
                h2c_data  = d;
                h2c_last  = lastFlag;
                @(posedge axi_aclk);
                #1;
                beat++;
                if (lastFlag) finished = 1;
            end
            rem -= fSize;
        end
        h2c_valid = 1'b0;
        h2c_last  = 1'b0;
        h2c_data  = '0;
    endtask

    initial begin
        axi_aresetn = 1'b0;
        control_reg = 32'h0;
        txr_size    = 16'h0;
        num_pkt     = 16'h0;
        h2c_valid   = 1'b0;
        h2c_last    = 1'b0;
        h2c_data    = '0;
        repeat (3) @(posedge axi_aclk);
        #1;
        checkAllZero("reset");
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;

        // Single 64-byte beat
        startRun(64, 1);
        checkOutput("t64 readyInRun", h2c_ready, 1);
        checkOutput("t64 doneBefore", done, 0);
        applyStimulus(64, -1, -1);
        checkOutput("t64 pktCount", pkt_count, 1);
        checkOutput("t64 errCount", err_count, 0);
        checkOutput("t64 byteCount", byte_count, 64);
        checkOutput("t64 done", done, 1);
        checkOutput("t64 readyDropped", h2c_ready, 0);
        checkOutput("t64 cycleCount", cycle_count, 1);

        // Two full frames, 128 beats
        startRun(8192, 1);
        applyStimulus(8192, -1, -1);
        checkOutput("t8192 pktCount", pkt_count, 1);
        checkOutput("t8192 errCount", err_count, 0);
        checkOutput("t8192 byteCount", byte_count, 8192);
        checkOutput("t8192 cycleCount", cycle_count, 128);
        checkOutput("t8192 done", done, 1);

        // Partial last beat, padding bytes ignored
        startRun(100, 1);
        applyStimulus(100, -1, -1);
        checkOutput("t100 errCount", err_count, 0);
        checkOutput("t100 errFlag", err_flag, 0);
        checkOutput("t100 byteCount", byte_count, 100);
        checkOutput("t100 pktCount", pkt_count, 1);

        // Payload corruption in packet 1 of 3
        startRun(64, 3);
        applyStimulus(64, -1, -1);
        applyStimulus(64, 20, -1);
        checkOutput("corrupt midPktCount", pkt_count, 2);
        checkOutput("corrupt midErrCount", err_count, 1);
        checkOutput("corrupt midReady", h2c_ready, 1);
        applyStimulus(64, -1, -1);
        checkOutput("corrupt errCount", err_count, 1);
        checkOutput("corrupt firstErr", first_err_pkt, 1);
        checkOutput("corrupt errFlag", err_flag, 1);
        checkOutput("corrupt pktCount", pkt_count, 3);
        checkOutput("corrupt done", done, 1);

        // Early h2c_last then a clean packet
        startRun(128, 2);
        applyStimulus(128, -1, 0);
        checkOutput("early pktCount", pkt_count, 1);
        checkOutput("early errCount", err_count, 1);
        checkOutput("early firstErr", first_err_pkt, 0);
        checkOutput("early done", done, 0);
        applyStimulus(128, -1, -1);
        checkOutput("early nextPktCount", pkt_count, 2);
        checkOutput("early nextErrCount", err_count, 1);
        checkOutput("early byteCount", byte_count, 192);
        checkOutput("early doneAfter", done, 1);

        // num_pkt of zero finishes right after start
        startRun(64, 0);
        checkOutput("zero doneAtStart", done, 0);
        @(posedge axi_aclk);
        #1;
        checkOutput("zero done", done, 1);
        checkOutput("zero ready", h2c_ready, 0);
        checkOutput("zero pktCount", pkt_count, 0);

        // Abort holds counters; abort wins over a simultaneous start
        startRun(64, 2);
        applyStimulus(64, -1, -1);
        checkOutput("abort preReady", h2c_ready, 1);
        control_reg = 32'h4;
        repeat (2) @(posedge axi_aclk);
        #1;
        checkOutput("abort ready", h2c_ready, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort pktHeld", pkt_count, 1);
        checkOutput("abort bytesHeld", byte_count, 64);
        control_reg = 32'h6;
        repeat (3) @(posedge axi_aclk);
        #1;
        checkOutput("abortPrio ready", h2c_ready, 0);
        checkOutput("abortPrio pktHeld", pkt_count, 1);
        control_reg = 32'h0;

        // Reset in the middle of a packet
        startRun(128, 1);
        h2c_valid = 1'b1;
        h2c_data  = makeBeat(0, 128);
        h2c_last  = 1'b0;
        @(posedge axi_aclk);
        #1;
        h2c_valid = 1'b0;
        checkOutput("midRst partialBytes", byte_count, 64);
        #2;
        axi_aresetn = 1'b0;
        #1;
        checkAllZero("midRst");
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        startRun(64, 1);
        applyStimulus(64, -1, -1);
        checkOutput("postRst pktCount", pkt_count, 1);
        checkOutput("postRst errCount", err_count, 0);
        checkOutput("postRst byteCount", byte_count, 64);
        checkOutput("postRst done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
